serial_accum_pe: RTL and testbench
==================================

Name: serial_accum_pe

Overview:
Bit-serial accumulating processing element for the systolic array. It sits directly downstream of the full-adder cell and wraps it with a carry flop, bit counter and accumulator shift register. Each PE consumes one operand word per WIDTH cycles, sent LSB-first. It adds the word into a committed accumulator, forwards operand and framing one cycle later to the next PE, and streams its own sum bits downstream.

Parameters:
WIDTH, 8, bits per operand word and accumulator width (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  clock enable; low = all state holds
start_in  input  1  marks LSB cycle of an operand word
clr_in  input  1  sampled with start_in: treat accumulator as 0 for this word
a_in  input  1  serial operand bit, LSB first
a_out  output  1  a_in registered (systolic pass-through)
start_out  output  1  start_in registered
clr_out  output  1  clr_in registered
sum_out  output  1  registered serial sum bit, aligned with a_out
acc_q  output  WIDTH  committed accumulator value
acc_valid  output  1  one-cycle pulse after acc_q commits
overflow  output  1  carry out of the MSB for the committed word; valid with acc_valid

Behaviour:
- Reset, asynchronous on rst_n low: all outputs 0, accumulator 0, carry 0, bit_cnt 0, state IDLE. Release is synchronous to clk.
- States: IDLE and RUN.
  - IDLE -> RUN on en & start_in, unless WIDTH==1, in which case the state stays IDLE.
  - RUN -> IDLE on en & bit_cnt==WIDTH-1.
  - In RUN, en & start_in aborts the current word and restarts at bit 0.
- Start cycle (en & start_in, any state):
  - acc bit = clr_in ? 0 : acc_q[0]; carry in = 0.
  - sum/carry = full_adder(a_in, acc bit, carry in).
  - shreg <= {sum, (clr_in ? 0 : acc_q[WIDTH-1:1])}; carry <= cout; bit_cnt <= 1.
- RUN cycle (en, no start):
  - sum/carry = full_adder(a_in, shreg[0], carry).
  - shreg <= {sum, shreg[WIDTH-1:1]}; carry <= cout; bit_cnt++.
- Last-bit cycle (bit_cnt==WIDTH-1, or the start cycle when WIDTH==1):
  - acc_q <= {sum, shreg[WIDTH-1:1]}, which equals (old acc + a) mod 2^WIDTH.
  - overflow <= cout; acc_valid <= 1 next cycle; carry cleared.
- acc_valid is 0 in every other cycle. overflow holds its value until the next commit.
- Abort leaves acc_q unchanged and produces no acc_valid; the partial shreg is discarded.
- a_in in IDLE without start_in is ignored. sum_out <= 0 in IDLE.
- Pass-through: a_out, start_out, clr_out and sum_out update only when en is high, with 1-cycle latency. sum_out carries the combinational sum of that cycle.
- en low: every register holds, including bit_cnt and carry. Words can be stalled arbitrarily mid-stream with no effect on the result. acc_valid is a registered pulse and clears on the next edge regardless of en.
- Reset mid-word: immediate return to reset values; the partial word is lost.
- Latency: acc_q and acc_valid appear WIDTH enabled cycles after the start cycle's edge.

Decomposition:
- Shared package: state enum (IDLE, RUN), CNT_W = max(1, $clog2(WIDTH)) constant function.
- One natural sub-module: the team's existing full_adder cell, instantiated with EN tied high. Its outputs are never high-Z here.
- Everything else stays inline.

Test Plan (WIDTH=8):
1. Assert rst_n=0 mid-simulation -> all outputs 0 within the same timestep. After release, no acc_valid until a start.
2. en=1, start+clr with word 0x2A (bits 0,1,0,1,0,1,0,0) -> acc_q=0x2A, overflow=0, single acc_valid pulse 8 cycles after the start edge. sum_out stream = 0,1,0,1,0,1,0,0.
3. Follow immediately with word 0xF0, no clr -> acc_q=0x1A, overflow=1. a_out/start_out echo inputs delayed exactly 1 cycle.
4. Repeat scenario 2 with en low for 3 cycles after bit 3 -> same acc_q=0x2A, acc_valid delayed by exactly 3 cycles, outputs frozen during the stall.
5. Word 0xFF started, then start_in re-asserted at bit 4 with clr=0 and new word 0x01 -> acc_q goes from prior value v to v+1. No acc_valid for the aborted word.
6. Pulse rst_n low at bit 5 of a word -> acc_q=0, state IDLE. The next clean word 0x05 with clr=0 gives acc_q=0x05.

Source files
------------

// File: rtl/serial_accum_pe_pkg.sv
// serial_accum_pe_pkg: shared state type and counter sizing for the serial accumulating PE
package serial_accum_pe_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_accum_pe_if.sv
// serial_accum_pe_if: serial operand stream in, systolic pass-through and accumulator result out
interface serial_accum_pe_if #(parameter int WIDTH = 8);
  logic             start_in;
  logic             clr_in;
  logic             a_in;
  logic             a_out;
  logic             start_out;
  logic             clr_out;
  logic             sum_out;
  logic [WIDTH-1:0] acc_q;
  logic             acc_valid;
  logic             overflow;
  modport master (
    output start_in, clr_in, a_in,
    input  a_out, start_out, clr_out, sum_out, acc_q, acc_valid, overflow
  );
  modport slave (
    input  start_in, clr_in, a_in,
    output a_out, start_out, clr_out, sum_out, acc_q, acc_valid, overflow
  );
endinterface

// File: rtl/serial_accum_pe_full_adder.sv
// full_adder: one-bit full adder cell with enable gating its outputs low
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  input  logic en,
  output logic s,
  output logic co
);
  assign s  = en & (a ^ b ^ ci);
  assign co = en & ((a & b) | (ci & (a ^ b)));
endmodule

// File: rtl/serial_accum_pe.sv
// serial_accum_pe: bit-serial LSB-first accumulator PE with systolic pass-through
module serial_accum_pe
  import serial_accum_pe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  input logic              en,
  serial_accum_pe_if.slave pe
);
  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             acc_valid_q, acc_valid_d;
  logic             overflow_q, overflow_d;
  logic             a_out_q, a_out_d;
  logic             start_out_q, start_out_d;
  logic             clr_out_q, clr_out_d;
  logic             sum_out_q, sum_out_d;
  logic             start, run, last, fa_b, fa_ci, sum, cout;
  logic [WIDTH-1:0] src, nxt;
  always_comb begin
    start = en & pe.start_in;
    run   = en & ~pe.start_in & (state_q == RUN);
    last  = start ? (WIDTH == 1) : run & (bit_cnt_q == LAST);
    src   = start ? (pe.clr_in ? '0 : acc_q) : shreg_q;
    fa_b  = src[0];
    fa_ci = ~start & carry_q;
    nxt   = (src >> 1) | (WIDTH'(sum) << (WIDTH - 1));
  end
  full_adder u_fa (
    .a (pe.a_in),
    .b (fa_b),
    .ci(fa_ci),
    .en(1'b1),
    .s (sum),
    .co(cout)
  );
  always_comb begin
    state_d     = last ? IDLE : start ? RUN : state_q;
    carry_d     = last ? 1'b0 : (start | run) ? cout : carry_q;
    bit_cnt_d   = last ? '0 : start ? CNT_W'(1) : run ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
    shreg_d     = (start | run) ? nxt : shreg_q;
    acc_d       = last ? nxt : acc_q;
    overflow_d  = last ? cout : overflow_q;
    acc_valid_d = last;
    a_out_d     = en ? pe.a_in : a_out_q;
    start_out_d = en ? pe.start_in : start_out_q;
    clr_out_d   = en ? pe.clr_in : clr_out_q;
    sum_out_d   = en ? (start | (state_q == RUN)) & sum : sum_out_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      carry_q     <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      acc_q       <= '0;
      acc_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      a_out_q     <= 1'b0;
      start_out_q <= 1'b0;
      clr_out_q   <= 1'b0;
      sum_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      overflow_q  <= overflow_d;
      a_out_q     <= a_out_d;
      start_out_q <= start_out_d;
      clr_out_q   <= clr_out_d;
      sum_out_q   <= sum_out_d;
    end
  end
  assign pe.acc_q     = acc_q;
  assign pe.acc_valid = acc_valid_q;
  assign pe.overflow  = overflow_q;
  assign pe.a_out     = a_out_q;
  assign pe.start_out = start_out_q;
  assign pe.clr_out   = clr_out_q;
  assign pe.sum_out   = sum_out_q;
endmodule

// File: tb/tb_serial_accum_pe.sv
// tb_serial_accum_pe: scoreboard bench for serial_accum_pe with directed words
module tb_serial_accum_pe;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  typedef struct {
    logic [7:0] acc;
    logic       ovf;
    int         at;
  } exp_t;
  exp_t sb[$];
  logic [7:0] acc_m = 8'h00;
  serial_accum_pe_if #(.WIDTH(8)) pe_if ();
  serial_accum_pe #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .pe   (pe_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pe_if.acc_valid) begin
      if (sb.size() == 0) chk("unexpected_acc_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("acc_q", int'(pe_if.acc_q), int'(e.acc));
        chk("overflow", int'(pe_if.overflow), int'(e.ovf));
        chk("acc_valid_cycle", cyc, e.at);
      end
    end
  end
  task automatic send(input logic [7:0] w, input bit clr, input int stall_after,
                      input int stall_len, input int nbits);
    logic [8:0] full;
    logic a_f, s_f, st_f;
    full = {1'b0, (clr ? 8'h00 : acc_m)} + {1'b0, w};
    if (nbits == 8) sb.push_back('{full[7:0], full[8], cyc + 8 + stall_len});
    for (int i = 0; i < nbits; i++) begin
      en = 1'b1;
      pe_if.start_in = (i == 0);
      pe_if.clr_in = (i == 0) && clr;
      pe_if.a_in = w[i];
      @(posedge clk);
      @(negedge clk);
      chk("sum_out", int'(pe_if.sum_out), int'(full[i]));
      chk("a_out", int'(pe_if.a_out), int'(w[i]));
      chk("start_out", int'(pe_if.start_out), (i == 0) ? 1 : 0);
      chk("clr_out", int'(pe_if.clr_out), (i == 0 && clr) ? 1 : 0);
      if (i == stall_after && stall_len > 0) begin
        en = 1'b0;
        a_f = pe_if.a_out;
        s_f = pe_if.sum_out;
        st_f = pe_if.start_out;
        pe_if.a_in = ~pe_if.a_in;
        pe_if.start_in = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          @(posedge clk);
          @(negedge clk);
          chk("stall_a_out", int'(pe_if.a_out), int'(a_f));
          chk("stall_sum_out", int'(pe_if.sum_out), int'(s_f));
          chk("stall_start_out", int'(pe_if.start_out), int'(st_f));
        end
      end
    end
    if (nbits == 8) acc_m = full[7:0];
    pe_if.start_in = 1'b0;
    pe_if.clr_in = 1'b0;
    pe_if.a_in = 1'b0;
  endtask
  initial begin
    pe_if.start_in = 1'b0;
    pe_if.clr_in = 1'b0;
    pe_if.a_in = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", int'({pe_if.a_out, pe_if.start_out, pe_if.clr_out, pe_if.sum_out,
                                  pe_if.acc_valid, pe_if.overflow}), 0);
    chk("reset_acc_q", int'(pe_if.acc_q), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    pe_if.a_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_sum_out", int'(pe_if.sum_out), 0);
    chk("idle_acc_q", int'(pe_if.acc_q), 0);
    pe_if.a_in = 1'b0;
    send(8'h2A, 1'b1, -1, 0, 8);
    send(8'hF0, 1'b0, -1, 0, 8);
    @(negedge clk);
    send(8'h2A, 1'b1, 3, 3, 8);
    repeat (2) @(negedge clk);
    send(8'hFF, 1'b0, -1, 0, 4);
    send(8'h01, 1'b0, -1, 0, 8);
    repeat (2) @(negedge clk);
    send(8'h3C, 1'b0, -1, 0, 5);
    pe_if.a_in = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("midword_reset_outputs", int'({pe_if.a_out, pe_if.start_out, pe_if.clr_out,
                                          pe_if.sum_out, pe_if.acc_valid, pe_if.overflow}), 0);
    chk("midword_reset_acc_q", int'(pe_if.acc_q), 0);
    acc_m = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    pe_if.a_in = 1'b0;
    repeat (3) @(negedge clk);
    send(8'h05, 1'b0, -1, 0, 8);
    repeat (4) @(negedge clk);
    chk("final_acc_q", int'(pe_if.acc_q), 8'h05);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
